// File: rtl/amba3_apb_mem_slave.sv
// APB3 completer with a zero-initialised word memory, fixed wait states and
// an error response for misaligned accesses.
module amba3_apb_mem_slave #(
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned MEM_WORDS_LOG2 = 8,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int unsigned Words = 2 ** MEM_WORDS_LOG2;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                    state_q, state_d;
    logic [3:0]                wait_q, wait_d;
    logic [DATA_SIZE-1:0]      mem_q [Words];
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic                      aligned;
    logic                      setup_phase;
    logic                      access_phase;
    logic                      write_en;
    logic                      unused_addr;

    assign idx          = paddr[MEM_WORDS_LOG2+1:2];
    assign aligned      = (paddr[1:0] == 2'b00);
    assign unused_addr  = ^paddr[ADDR_SIZE-1:MEM_WORDS_LOG2+2];
    assign setup_phase  = psel && !penable;
    // An access phase is only honoured when it follows a setup (or a stalled access).
    assign access_phase = psel && penable && (state_q != StIdle);
    assign pready       = (wait_q == 4'd0);
    assign pslverr      = access_phase && pready && !aligned;
    assign write_en     = access_phase && pready && pwrite && aligned;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle:   state_d = setup_phase ? StSetup : StIdle;
            StSetup:  state_d = access_phase ? StAccess : (setup_phase ? StSetup : StIdle);
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (penable) begin
                    state_d = StAccess;
                end else begin
                    state_d = StSetup;
                end
            end
            default:  state_d = StIdle;
        endcase

        // Dropping psel aborts any transfer in flight and clears the counter.
        if (!psel) begin
            wait_d = 4'd0;
        end else if (setup_phase) begin
            wait_d = 4'(WAIT_STATES);
        end else if (access_phase && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (setup_phase) begin
                prdata <= aligned ? mem_q[idx] : '0;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[idx] <= pwdata;
        end
    end

endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
// Scoreboarded random/directed bench for the APB3 memory slave; one instance
// with no wait states and one with three, sharing the bus apart from psel.
module tb_amba3_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    always #5 pclk = ~pclk;

    amba3_apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    amba3_apb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [2][256];
    bit          touched [256];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] basic_addr [4] = '{32'h00, 32'h04, 32'h10, 32'h18};
    logic [31:0] basic_data [4] = '{32'h04, 32'h08, 32'h14, 32'h1C};

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 256; i++) begin
            model[0][i] = '0;
            model[1][i] = '0;
            touched[i]  = 1'b0;
        end
    endfunction

    // Monitor: pops one expectation per completing access phase.
    int          cyc = 0;
    int          wcyc = 0;
    bit          md;
    logic        m_rdy, m_err;
    logic [31:0] m_data;
    exp_t        m_e;

    always @(negedge pclk) begin
        if (preset) begin
            cyc  = 0;
            wcyc = 0;
        end else if (psel0 || psel3) begin
            md     = psel3;
            m_rdy  = md ? pready3 : pready0;
            m_err  = md ? pslverr3 : pslverr0;
            m_data = md ? prdata3 : prdata0;
            cyc++;
            if (penable && !m_rdy) wcyc++;
            if (penable && m_rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("pslverr", 32'(m_err), 32'(m_e.err));
                    if (m_e.rd) chk("prdata", m_data, m_e.data);
                    chk("length", 32'(cyc), md ? 32'd5 : 32'd2);
                    chk("wait_cycles", 32'(wcyc), md ? 32'd3 : 32'd0);
                end
                cyc  = 0;
                wcyc = 0;
            end else begin
                chk("pslverr_not_done", 32'(m_err), 32'd0);
            end
        end else begin
            cyc  = 0;
            wcyc = 0;
            chk("pslverr_unselected", 32'(pslverr0 | pslverr3), 32'd0);
        end
    end

    // Entered at a rising edge; returns at the completing edge.
    task automatic xfer(input bit d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit b2b);
        exp_t e;
        bit   al;
        int   idx;
        int   n;
        al     = (addr[1:0] == 2'b00);
        idx    = int'(addr[9:2]);
        e.rd   = !wr;
        e.err  = !al;
        e.data = al ? model[d][idx] : 32'h0;
        if (wr && al) begin
            model[d][idx] = data;
            if (!d) touched[idx] = 1'b1;
        end
        q.push_back(e);
        #1;
        psel0   = !d;
        psel3   = d;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk);
        #1 penable = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            if ((d ? pready3 : pready0) === 1'b1) break;
            n++;
            if (n > 20) begin
                $display("FAIL pready_timeout actual=low required=high");
                $fatal(1, "pready never rose");
            end
            @(posedge pclk);
        end
        @(posedge pclk);
        if (!b2b) begin
            #1;
            psel0   = 1'b0;
            psel3   = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge pclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        clear_model();
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        chk("rst_pready0", 32'(pready0), 32'd1);
        chk("rst_pready3", 32'(pready3), 32'd1);
        chk("rst_prdata0", prdata0, 32'd0);
        chk("rst_pslverr3", 32'(pslverr3), 32'd0);
        @(posedge pclk);

        // Basic writes then reads on both wait-state variants.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                xfer(d[0], 1'b1, basic_addr[i], basic_data[i], 1'b0);
                idle(int'($urandom_range(0, 10)));
            end
            for (int i = 0; i < 4; i++) begin
                xfer(d[0], 1'b0, basic_addr[i], 32'h0, 1'b0);
                idle(int'($urandom_range(0, 10)));
            end
        end

        // Back-to-back, no idle cycles.
        xfer(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b1);
        xfer(1'b0, 1'b1, 32'h80, 32'h4050_6070, 1'b1);
        xfer(1'b0, 1'b1, 32'h88, 32'h2244_6688, 1'b1);
        xfer(1'b0, 1'b0, 32'h88, 32'h0, 1'b1);
        xfer(1'b0, 1'b0, 32'h40, 32'h0, 1'b1);
        xfer(1'b0, 1'b0, 32'h80, 32'h0, 1'b0);
        idle(2);

        // Error responses, then clean aligned traffic.
        xfer(1'b0, 1'b1, 32'h42, 32'hFFFF_FFFF, 1'b0);
        xfer(1'b0, 1'b0, 32'h41, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        xfer(1'b0, 1'b1, 32'h44, 32'hCAFE_0044, 1'b1);
        xfer(1'b0, 1'b0, 32'h44, 32'h0, 1'b0);
        xfer(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        xfer(1'b1, 1'b1, 32'h0E, 32'h5555_AAAA, 1'b0);
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);
        idle(2);

        // Random soak across the full address space (aliasing exercised).
        for (int i = 0; i < 1000; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            xfer(1'b0, 1'b1, a, $urandom, (i != 999) && ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 256; i++) begin
            if (touched[i]) begin
                a = ($urandom & 32'hFFFF_FC00) | (32'(i) << 2);
                xfer(1'b0, 1'b0, a, 32'h0, 1'b0);
            end
        end
        idle(2);

        // Reset during the stalled access phase of a write.
        #1;
        psel3   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h20;
        pwdata  = 32'h0000_DEAD;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1;
        preset  = 1'b1;
        psel3   = 1'b0;
        penable = 1'b0;
        clear_model();
        #1 chk("mid_rst_pready3", 32'(pready3), 32'd1);
        chk("mid_rst_prdata0", prdata0, 32'd0);
        @(posedge pclk);
        #1 preset = 1'b0;
        @(posedge pclk);
        xfer(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h00, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0);
        idle(3);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
